// File: rtl/shiftadd_mult_datapath_if.sv
// Bus between the shift-add control FSM (master) and its datapath (slave):
// operands, per-cycle strobes, and the status/product returned to the FSM.
interface shiftadd_mult_datapath_if #(
    parameter int WIDTH = 4
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;
    logic               load;
    logic               add;
    logic               shift;
    logic               ld_count;
    logic               done;
    logic               lsb;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] product;
    logic               product_valid;
    logic               seq_err;

    modport master (
        output a_in, b_in, load, add, shift, ld_count, done,
        input  lsb, count, product, product_valid, seq_err
    );

    modport slave (
        input  a_in, b_in, load, add, shift, ld_count, done,
        output lsb, count, product, product_valid, seq_err
    );
endinterface

// File: rtl/shiftadd_mult_datapath.sv
// Shift-add multiplier datapath: multiplicand, {carry,acc,mq} shift chain,
// iteration counter and strobe-sequence checking for the control FSM.
// Optional feature macro: SHIFTADD_OUT_REG_EN (registered product output
// captured on done; otherwise the product is the live {acc,mq}).
// WIDTH must match the WIDTH of the connected interface instance.
module shiftadd_mult_datapath #(
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    shiftadd_mult_datapath_if.slave    bus
);
    localparam int COUNT_DEPTH = $clog2(WIDTH);
    localparam int CW          = COUNT_DEPTH + 1;

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] mq_q,    mq_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             armed_q, armed_d;
    logic             seq_err_q, seq_err_d;
    logic [WIDTH:0]   addv;

    // Next-state: load wins, otherwise apply add/shift/ld_count/done when armed.
    always_comb begin
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        mq_d      = mq_q;
        cnt_d     = cnt_q;
        armed_d   = armed_q;
        seq_err_d = seq_err_q;
        addv      = {carry_q, acc_q};

        if (bus.load) begin
            mcand_d   = bus.a_in;
            mq_d      = bus.b_in;
            acc_d     = '0;
            carry_d   = 1'b0;
            cnt_d     = '0;
            armed_d   = 1'b1;
            seq_err_d = 1'b0;
        end else if (!armed_q) begin
            if (bus.add || bus.shift || bus.ld_count || bus.done) begin
                seq_err_d = 1'b1;
            end
        end else begin
            // Sum is formed first so a fused add+shift shifts the new value.
            if (bus.add) begin
                addv    = {1'b0, acc_q} + {1'b0, mcand_q};
                carry_d = addv[WIDTH];
                acc_d   = addv[WIDTH-1:0];
            end
            if (bus.shift) begin
                mq_d    = {addv[0], mq_q[WIDTH-1:1]};
                acc_d   = addv[WIDTH:1];
                carry_d = 1'b0;
            end
            if (bus.ld_count) begin
                if (cnt_q < CW'(WIDTH)) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    seq_err_d = 1'b1;
                end
            end
            if (bus.done) begin
                armed_d = 1'b0;
            end
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q   <= '0;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            mq_q      <= '0;
            cnt_q     <= '0;
            armed_q   <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            carry_q   <= carry_d;
            mq_q      <= mq_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign bus.lsb     = mq_q[0];
    assign bus.count   = cnt_q;
    assign bus.seq_err = seq_err_q;

`ifdef SHIFTADD_OUT_REG_EN
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               pvalid_q, pvalid_d;

    // Capture the finished product on a qualifying done; pulse valid once.
    always_comb begin
        prod_d   = prod_q;
        pvalid_d = 1'b0;
        if (bus.done && armed_q) begin
            prod_d   = {acc_q, mq_q};
            pvalid_d = 1'b1;
        end
    end

    // Output register; untouched by load so the last result stays visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q   <= '0;
            pvalid_q <= 1'b0;
        end else begin
            prod_q   <= prod_d;
            pvalid_q <= pvalid_d;
        end
    end

    assign bus.product       = prod_q;
    assign bus.product_valid = pvalid_q;
`else
    assign bus.product       = {acc_q, mq_q};
    assign bus.product_valid = bus.done & armed_q;
`endif
endmodule

// File: tb/tb_shiftadd_mult_datapath.sv
// Directed bench for shiftadd_mult_datapath (WIDTH=4, default build).
module tb_shiftadd_mult_datapath;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    shiftadd_mult_datapath_if #(.WIDTH(4)) bus ();

    shiftadd_mult_datapath #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
        bit         fused;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic ld, input logic ad, input logic sh,
                        input logic lc, input logic dn);
        bus.load     = ld;
        bus.add      = ad;
        bus.shift    = sh;
        bus.ld_count = lc;
        bus.done     = dn;
        @(posedge clk);
        #1;
        bus.load     = 1'b0;
        bus.add      = 1'b0;
        bus.shift    = 1'b0;
        bus.ld_count = 1'b0;
        bus.done     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic load_ops(input logic [3:0] a, input logic [3:0] b);
        bus.a_in = a;
        bus.b_in = b;
        step(1, 0, 0, 0, 0);
    endtask

    // One FSM-style iteration driven from the expected multiplier bit.
    task automatic iterate(input logic bit_i, input bit fused);
        if (fused) begin
            step(0, bit_i, 1, 1, 0);
        end else begin
            if (bit_i) step(0, 1, 0, 0, 0);
            step(0, 0, 1, 1, 0);
        end
    endtask

    task automatic run_vec(input logic [3:0] a, input logic [3:0] b,
                           input logic [7:0] exp, input bit fused);
        load_ops(a, b);
        chk("count_after_load", 32'(bus.count), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("lsb_a%0d_b%0d_it%0d", a, b, i), 32'(bus.lsb), 32'(b[i]));
            iterate(b[i], fused);
        end
        chk($sformatf("count_a%0d_b%0d", a, b), 32'(bus.count), 32'd4);
        chk($sformatf("product_a%0d_b%0d", a, b), 32'(bus.product), 32'(exp));
        chk($sformatf("seq_err_a%0d_b%0d", a, b), 32'(bus.seq_err), 32'd0);
        bus.done = 1'b1;
        #1;
        chk($sformatf("pvalid_a%0d_b%0d", a, b), 32'(bus.product_valid), 32'd1);
        @(posedge clk);
        #1;
        bus.done = 1'b0;
        chk($sformatf("seq_err_done_a%0d_b%0d", a, b), 32'(bus.seq_err), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst          = 1'b0;
        bus.a_in     = '0;
        bus.b_in     = '0;
        bus.load     = 1'b0;
        bus.add      = 1'b0;
        bus.shift    = 1'b0;
        bus.ld_count = 1'b0;
        bus.done     = 1'b0;

        vecs[0] = '{a: 4'd13, b: 4'd11, exp: 8'd143, fused: 1'b0};
        vecs[1] = '{a: 4'd15, b: 4'd15, exp: 8'd225, fused: 1'b0};
        vecs[2] = '{a: 4'd0,  b: 4'd15, exp: 8'd0,   fused: 1'b0};
        vecs[3] = '{a: 4'd9,  b: 4'd0,  exp: 8'd0,   fused: 1'b0};
        vecs[4] = '{a: 4'd5,  b: 4'd3,  exp: 8'd15,  fused: 1'b1};
        vecs[5] = '{a: 4'd15, b: 4'd13, exp: 8'd195, fused: 1'b1};

        // Reset state
        do_reset();
        chk("rst_lsb",     32'(bus.lsb),           32'd0);
        chk("rst_count",   32'(bus.count),         32'd0);
        chk("rst_product", 32'(bus.product),       32'd0);
        chk("rst_pvalid",  32'(bus.product_valid), 32'd0);
        chk("rst_seq_err", 32'(bus.seq_err),       32'd0);

        // Table-driven full runs
        for (int v = 0; v < 6; v++) begin
            run_vec(vecs[v].a, vecs[v].b, vecs[v].exp, vecs[v].fused);
        end

        // Fused add+shift on first iteration of 5*3
        load_ops(4'd5, 4'd3);
        step(0, 1, 1, 1, 0);
        chk("fused_it1_product", 32'(bus.product), 32'h29);
        chk("fused_it1_count",   32'(bus.count),   32'd1);
        chk("fused_it1_lsb",     32'(bus.lsb),     32'd1);

        // Strobes coinciding with load are ignored
        bus.a_in = 4'd3;
        bus.b_in = 4'd3;
        step(1, 1, 1, 1, 0);
        chk("load_ign_count",   32'(bus.count),   32'd0);
        chk("load_ign_product", 32'(bus.product), 32'h03);

        // Counter saturation and error
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0);
        chk("cnt4_count",   32'(bus.count),   32'd4);
        chk("cnt4_seq_err", 32'(bus.seq_err), 32'd0);
        step(0, 0, 0, 1, 0);
        chk("cnt5_count",   32'(bus.count),   32'd4);
        chk("cnt5_seq_err", 32'(bus.seq_err), 32'd1);
        load_ops(4'd1, 4'd2);
        chk("reload_seq_err", 32'(bus.seq_err), 32'd0);
        chk("reload_count",   32'(bus.count),   32'd0);

        // Shift with no prior load
        do_reset();
        step(0, 0, 1, 0, 0);
        chk("noload_shift_seq_err", 32'(bus.seq_err), 32'd1);
        chk("noload_shift_product", 32'(bus.product), 32'd0);
        chk("noload_shift_count",   32'(bus.count),   32'd0);

        // Done with no prior load
        do_reset();
        bus.done = 1'b1;
        #1;
        chk("noload_done_pvalid", 32'(bus.product_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.done = 1'b0;
        chk("noload_done_seq_err", 32'(bus.seq_err), 32'd1);

        // Strobes after done are ignored and flagged
        run_vec(4'd13, 4'd11, 8'd143, 1'b0);
        step(0, 1, 1, 1, 0);
        chk("postdone_product", 32'(bus.product), 32'h8F);
        chk("postdone_count",   32'(bus.count),   32'd4);
        chk("postdone_seq_err", 32'(bus.seq_err), 32'd1);

        // Reset during iteration 2
        load_ops(4'd13, 4'd11);
        iterate(1'b1, 1'b0);
        chk("it1_product", 32'(bus.product), 32'h6D);
        step(0, 1, 0, 0, 0);
        rst = 1'b1;
        step(0, 0, 1, 1, 0);
        rst = 1'b0;
        chk("midrst_lsb",     32'(bus.lsb),     32'd0);
        chk("midrst_count",   32'(bus.count),   32'd0);
        chk("midrst_product", 32'(bus.product), 32'd0);
        chk("midrst_seq_err", 32'(bus.seq_err), 32'd0);

        // Load mid-run restarts cleanly
        load_ops(4'd13, 4'd11);
        iterate(1'b1, 1'b0);
        iterate(1'b1, 1'b0);
        run_vec(4'd7, 4'd6, 8'd42, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
